// File: rtl/hazard5_ahbl_arbiter.sv
// AHB-Lite N:1 arbiter: per-source address-phase buffering, one downstream master.
// Ports: src_* packed per-source buses (slice i*W+:W), m_* downstream master, clk/rst_n.
// Build option: HAZARD5_ARB_ROUND_ROBIN_EN selects round-robin; default is fixed priority.
module hazard5_ahbl_arbiter #(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS*W_ADDR-1:0]   src_haddr,
  input  logic [2*N_PORTS-1:0]        src_htrans,
  input  logic [N_PORTS-1:0]          src_hwrite,
  input  logic [3*N_PORTS-1:0]        src_hsize,
  input  logic [4*N_PORTS-1:0]        src_hprot,
  input  logic [N_PORTS*W_DATA-1:0]   src_hwdata,
  output logic [N_PORTS-1:0]          src_hready,
  output logic [N_PORTS-1:0]          src_hresp,
  output logic [N_PORTS*W_DATA-1:0]   src_hrdata,
  output logic [W_ADDR-1:0]           m_haddr,
  output logic [1:0]                  m_htrans,
  output logic                        m_hwrite,
  output logic [2:0]                  m_hsize,
  output logic [3:0]                  m_hprot,
  output logic [W_DATA-1:0]           m_hwdata,
  input  logic                        m_hready,
  input  logic                        m_hresp,
  input  logic [W_DATA-1:0]           m_hrdata
);

  localparam int W_IDX = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [1:0] HT_IDLE = 2'b00;
  localparam logic [1:0] HT_NSEQ = 2'b10;

  logic [N_PORTS-1:0] dph;
  logic [N_PORTS-1:0] held;
  logic [N_PORTS-1:0] owner_hit;
  logic [N_PORTS-1:0] live;
  logic [N_PORTS-1:0] cand;
  logic [N_PORTS-1:0] gnt;

  logic [W_ADDR-1:0]  buf_addr  [N_PORTS];
  logic [N_PORTS-1:0] buf_write;
  logic [2:0]         buf_size  [N_PORTS];
  logic [3:0]         buf_prot  [N_PORTS];

  logic               dph_valid;
  logic [W_IDX-1:0]   dph_owner;

  logic               gnt_any;
  logic [W_IDX-1:0]   gnt_idx;

  logic [W_ADDR-1:0]  last_addr;
  logic [1:0]         last_htrans;
  logic               last_write;
  logic [2:0]         last_size;
  logic [3:0]         last_prot;

  always_comb begin
    owner_hit  = '0;
    src_hready = '0;
    src_hresp  = '0;
    live       = '0;
    cand       = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      owner_hit[i]  = dph_valid && (dph_owner == W_IDX'(i));
      src_hready[i] = !dph[i] ||
                      (m_hready && owner_hit[i] && !held[i]);
      src_hresp[i]  = m_hresp && owner_hit[i];
      // gating with rst_n keeps the downstream bus idle during reset
      live[i]       = rst_n && src_hready[i] &&
                      src_htrans[2*i+1];
      cand[i]       = held[i] || live[i];
    end
  end

`ifdef HAZARD5_ARB_ROUND_ROBIN_EN
  logic [W_IDX-1:0] rr_ptr;

  function automatic int wrap(input int v);
    return (v >= N_PORTS) ? v - N_PORTS : v;
  endfunction

  // scan from lowest to highest priority so the
  // last match (offset 0 from rr_ptr) wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (m_hready && cand[wrap(int'(rr_ptr) + k)]) begin
        gnt_any = 1'b1;
        gnt_idx = W_IDX'(wrap(int'(rr_ptr) + k));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= W_IDX'(wrap(int'(gnt_idx) + 1));
    end
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (m_hready && cand[k]) begin
        gnt_any = 1'b1;
        gnt_idx = W_IDX'(k);
      end
    end
  end
`endif

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      gnt[i] = gnt_any && (gnt_idx == W_IDX'(i));
    end
  end

  // while the downstream stalls the address bus holds
  // whatever it showed on the previous cycle
  always_comb begin
    m_htrans = last_htrans;
    m_haddr  = last_addr;
    m_hwrite = last_write;
    m_hsize  = last_size;
    m_hprot  = last_prot;
    if (m_hready) begin
      m_htrans = gnt_any ? HT_NSEQ : HT_IDLE;
      if (gnt_any) begin
        if (held[gnt_idx]) begin
          m_haddr  = buf_addr[gnt_idx];
          m_hwrite = buf_write[gnt_idx];
          m_hsize  = buf_size[gnt_idx];
          m_hprot  = buf_prot[gnt_idx];
        end else begin
          m_haddr  = src_haddr[gnt_idx*W_ADDR +: W_ADDR];
          m_hwrite = src_hwrite[gnt_idx];
          m_hsize  = src_hsize[gnt_idx*3 +: 3];
          m_hprot  = src_hprot[gnt_idx*4 +: 4];
        end
      end
    end
  end

  assign m_hwdata   = src_hwdata[dph_owner*W_DATA +: W_DATA];
  assign src_hrdata = {N_PORTS{m_hrdata}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dph         <= '0;
      held        <= '0;
      dph_valid   <= 1'b0;
      dph_owner   <= '0;
      last_htrans <= HT_IDLE;
      last_addr   <= '0;
      last_write  <= 1'b0;
      last_size   <= '0;
      last_prot   <= '0;
    end else begin
      last_htrans <= m_htrans;
      last_addr   <= m_haddr;
      last_write  <= m_hwrite;
      last_size   <= m_hsize;
      last_prot   <= m_hprot;
      if (m_hready) begin
        dph_valid <= gnt_any;
        if (gnt_any) begin
          dph_owner <= gnt_idx;
        end
      end
      for (int i = 0; i < N_PORTS; i++) begin
        if (src_hready[i]) begin
          dph[i] <= live[i];
        end
        if (gnt[i]) begin
          held[i] <= 1'b0;
        end else if (live[i]) begin
          held[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_write <= '0;
      for (int i = 0; i < N_PORTS; i++) begin
        buf_addr[i] <= '0;
        buf_size[i] <= '0;
        buf_prot[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (live[i] && !gnt[i]) begin
          buf_addr[i]  <= src_haddr[i*W_ADDR +: W_ADDR];
          buf_write[i] <= src_hwrite[i];
          buf_size[i]  <= src_hsize[i*3 +: 3];
          buf_prot[i]  <= src_hprot[i*4 +: 4];
        end
      end
    end
  end

endmodule
